serial_hadd_adder: RTL and testbench
====================================

Name: serial_hadd_adder

Overview:
Bit-serial N-bit adder that consumes one bit slice per cycle through a carry-save pair of half-adder cells (two half adders plus an OR form one full-adder slice) and a registered carry. It sits downstream of the single-cycle half-adder gate stage and produces a full-width sum over multiple cycles. It uses a latency-insensitive val/rdy interface on both sides. Intended as the area-minimal adder for datapaths where throughput is not critical.

Parameters:
NBITS, 8, operand and sum width in bits; legal range is 1 to 32.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
in_val  input  1  operand pair valid
in_rdy  output  1  block can accept an operand pair
in_a  input  NBITS  operand A
in_b  input  NBITS  operand B
out_val  output  1  result valid
out_rdy  input  1  consumer accepts the result
out_sum  output  NBITS  (A+B) mod 2^NBITS
out_cout  output  1  carry out of bit NBITS-1

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While reset=0: state=IDLE, carry=0, bit counter=0, out_sum=0, out_cout=0, out_val=0, in_rdy=0.
  - Assertion takes effect immediately, with no clock edge needed.
  - Reset asserted mid-operation aborts the operation. The partial result is discarded and never presented.
- States: IDLE, CALC, DONE.
  - in_rdy = (state==IDLE) && reset deasserted.
  - out_val = (state==DONE).
- IDLE:
  - On an edge with in_val && in_rdy, latch in_a/in_b into shift registers, clear carry and counter, and go to CALC.
  - in_val with in_rdy=0 is ignored. The producer must hold the operands.
- CALC, one slice per edge, LSB first:
  - s1=a_i^b_i, c1=a_i&b_i.
  - sum_i=s1^carry, c2=s1&carry.
  - carry<=c1|c2.
  - sum_i is shifted into the result register from the MSB end, so bit 0 lands at out_sum[0] after NBITS shifts.
  - Counter increments each edge. On the edge that processes bit NBITS-1, go to DONE and set out_cout to the final carry.
- Latency:
  - Accept edge is E0.
  - Edges E1..E_NBITS process bits 0..NBITS-1.
  - out_val is high after edge E_NBITS.
  - The accept-to-valid latency is NBITS cycles; for NBITS=1, out_val is high one cycle after accept.
- DONE:
  - out_sum and out_cout hold stable while out_val=1 and out_rdy=0 (backpressure of any length).
  - On an edge with out_rdy=1, return to IDLE.
  - out_sum and out_cout keep their last values after out_val drops. They are not guaranteed meaningful then.
- No overlap: a new operand pair is accepted at the earliest one cycle after the result transfer, so the maximum throughput is one add per NBITS+2 cycles.
- Inputs in_a/in_b may change freely after the accept edge without affecting the result.
- out_rdy during IDLE/CALC is ignored.
- Arithmetic:
  - out_sum equals (in_a+in_b)[NBITS-1:0].
  - out_cout equals (in_a+in_b)[NBITS].
  - Unsigned; no overflow flag.

Test Plan:
- Reset defaults: hold reset=0 for 2 cycles, then release. in_rdy=1, out_val=0, out_sum=0x00, out_cout=0.
- Directed adds with NBITS=8 and out_rdy=1. Each result must appear exactly 8 cycles after accept:
  - 0x00+0x00 gives sum 0x00, cout 0.
  - 0xFF+0x01 gives sum 0x00, cout 1 (full carry ripple).
  - 0xA5+0x5A gives sum 0xFF, cout 0.
  - 0x80+0x80 gives sum 0x00, cout 1.
- Backpressure:
  - Add 0x3C+0x0F and hold out_rdy=0 for 5 cycles. out_val stays 1 and sum 0x4B stays stable, with in_rdy=0 throughout.
  - Raise out_rdy. Transfer occurs, and in_rdy=1 the next cycle.
- Back-to-back:
  - in_val held high with pairs (1,2), (7,9), (0xFE,0x03).
  - Results must be 0x03/0, 0x10/0, 0x01/1, in order.
  - Accepts must be spaced by NBITS+2=10 cycles.
- Reset mid-operation:
  - Accept 0xFF+0xFF, then assert reset at the 4th CALC cycle, between edges. Outputs clear immediately.
  - After release, 0x01+0x01 must yield 0x02/0, with no leftover carry.
- Width boundary, NBITS=1 build:
  - 1+1 gives sum 0, cout 1, valid 1 cycle after accept.
  - 1+0 gives sum 1, cout 0.

Source files
------------

// File: rtl/serial_hadd_adder.sv
// Bit-serial N-bit adder: one bit slice per cycle through two half-adder cells plus an OR, with a registered carry.
// Accept-to-valid latency is NBITS cycles; the result holds under out_rdy backpressure and no new pair is taken until it transfers.
module serial_hadd_adder #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_sum,
  output logic             out_cout
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int             CW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(NBITS - 1);

  state_t           state_q;
  logic [NBITS-1:0] a_q, b_q, sum_q;
  logic [NBITS-1:0] sum_d;
  logic             carry_q, carry_d, cout_q;
  logic [CW-1:0]    cnt_q;

  logic s1, c1, sum_bit, c2;

  // Two half adders and an OR make up one full-adder slice.
  assign s1      = a_q[0] ^ b_q[0];
  assign c1      = a_q[0] & b_q[0];
  assign sum_bit = s1 ^ carry_q;
  assign c2      = s1 & carry_q;
  assign carry_d = c1 | c2;

  // New bit enters at the MSB so bit 0 reaches out_sum[0] after NBITS shifts.
  always_comb begin
    sum_d            = sum_q >> 1;
    sum_d[NBITS-1]   = sum_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_val) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q  <= carry_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_rdy   = (state_q == IDLE) && reset;
  assign out_val  = (state_q == DONE);
  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_serial_hadd_adder.sv
// Directed bench for serial_hadd_adder: an 8-bit build for the main function and a 1-bit build for the width boundary.
module tb_serial_hadd_adder;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_val, in_rdy, out_val, out_rdy, out_cout;
  logic [7:0] in_a, in_b, out_sum;

  logic       in_val1, in_rdy1, out_val1, out_rdy1, out_cout1;
  logic [0:0] in_a1, in_b1, out_sum1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_hadd_adder #(.NBITS(8)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .out_val(out_val), .out_rdy(out_rdy), .out_sum(out_sum), .out_cout(out_cout)
  );

  serial_hadd_adder #(.NBITS(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_val(in_val1), .in_rdy(in_rdy1), .in_a(in_a1), .in_b(in_b1),
    .out_val(out_val1), .out_rdy(out_rdy1), .out_sum(out_sum1), .out_cout(out_cout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One add on the 8-bit build with out_rdy=1; checks latency, result and the return to IDLE.
  task automatic run_add(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_sum, input logic exp_cout);
    int lat;
    int w;
    w = 0;
    while (!in_rdy && w < 30) begin tick(); w++; end
    check({name, " in_rdy before accept"}, 32'(in_rdy), 32'd1);
    in_val = 1'b1; in_a = a; in_b = b;
    tick();
    in_val = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_val) begin lat = k; break; end
    end
    check({name, " latency"}, 32'(lat), 32'd8);
    check({name, " sum"}, 32'(out_sum), 32'(exp_sum));
    check({name, " cout"}, 32'(out_cout), 32'(exp_cout));
    tick();
    check({name, " idle after transfer"}, {30'd0, out_val, in_rdy}, 32'b01);
  endtask

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } pair_t;

  pair_t pairs[3];
  logic [7:0] got_sum[3];
  logic       got_cout[3];
  int         acc_cyc[3];

  initial begin
    vecs[0] = '{"zero",   8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{"ripple", 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{"alt",    8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[3] = '{"msb",    8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{"7f+1",   8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{"c8+64",  8'hC8, 8'h64, 8'h2C, 1'b1};
    pairs[0] = '{8'h01, 8'h02, 8'h03, 1'b0};
    pairs[1] = '{8'h07, 8'h09, 8'h10, 1'b0};
    pairs[2] = '{8'hFE, 8'h03, 8'h01, 1'b1};

    reset = 1'b0;
    in_val = 1'b0; in_a = '0; in_b = '0; out_rdy = 1'b1;
    in_val1 = 1'b0; in_a1 = '0; in_b1 = '0; out_rdy1 = 1'b1;
    tick();
    check("in_rdy low in reset", 32'(in_rdy), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("reset in_rdy",  32'(in_rdy),   32'd1);
    check("reset out_val", 32'(out_val),  32'd0);
    check("reset out_sum", 32'(out_sum),  32'h00);
    check("reset out_cout",32'(out_cout), 32'd0);

    foreach (vecs[i]) run_add(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);

    // Backpressure: result must hold for five stalled cycles.
    out_rdy = 1'b0;
    in_val = 1'b1; in_a = 8'h3C; in_b = 8'h0F;
    tick();
    in_val = 1'b0; in_a = 8'hAA; in_b = 8'h55;
    for (int k = 0; k < 20 && !out_val; k++) tick();
    for (int k = 0; k < 5; k++) begin
      check("bp out_val", 32'(out_val), 32'd1);
      check("bp sum",     32'(out_sum), 32'h4B);
      check("bp cout",    32'(out_cout), 32'd0);
      check("bp in_rdy",  32'(in_rdy), 32'd0);
      tick();
    end
    out_rdy = 1'b1;
    tick();
    check("bp released out_val", 32'(out_val), 32'd0);
    check("bp released in_rdy",  32'(in_rdy),  32'd1);

    // Back-to-back with in_val held high.
    begin
      int cyc, idx, nres;
      logic acc;
      cyc = 0; idx = 0; nres = 0;
      in_val = 1'b1; in_a = pairs[0].a; in_b = pairs[0].b;
      while (cyc < 100 && nres < 3) begin
        acc = in_val && in_rdy;
        if (acc) acc_cyc[idx] = cyc;
        if (out_val) begin
          got_sum[nres] = out_sum; got_cout[nres] = out_cout; nres++;
        end
        tick();
        cyc++;
        if (acc) begin
          idx++;
          if (idx < 3) begin in_a = pairs[idx].a; in_b = pairs[idx].b; end
          else in_val = 1'b0;
        end
      end
      check("b2b result count", 32'(nres), 32'd3);
      for (int i = 0; i < nres; i++) begin
        check($sformatf("b2b sum %0d", i),  32'(got_sum[i]),  32'(pairs[i].sum));
        check($sformatf("b2b cout %0d", i), 32'(got_cout[i]), 32'(pairs[i].cout));
      end
      if (nres == 3) begin
        check("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
        check("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
      end
    end

    // Reset in the middle of a calculation aborts it immediately.
    tick();
    in_val = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    tick();
    in_val = 1'b0;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst in_rdy",  32'(in_rdy),   32'd0);
    check("midrst out_val", 32'(out_val),  32'd0);
    check("midrst out_sum", 32'(out_sum),  32'h00);
    check("midrst out_cout",32'(out_cout), 32'd0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("post-rst out_val", 32'(out_val), 32'd0);
    run_add("post-rst 1+1", 8'h01, 8'h01, 8'h02, 1'b0);

    // One-bit build.
    for (int t = 0; t < 2; t++) begin
      int lat;
      logic exp_s, exp_c;
      exp_s = (t == 0) ? 1'b0 : 1'b1;
      exp_c = (t == 0) ? 1'b1 : 1'b0;
      check($sformatf("w1 in_rdy %0d", t), 32'(in_rdy1), 32'd1);
      in_val1 = 1'b1; in_a1 = 1'b1; in_b1 = (t == 0) ? 1'b1 : 1'b0;
      tick();
      in_val1 = 1'b0; in_a1 = 1'b0; in_b1 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (out_val1) begin lat = k; break; end
      end
      check($sformatf("w1 latency %0d", t), 32'(lat), 32'd1);
      check($sformatf("w1 sum %0d", t),  32'(out_sum1),  32'(exp_s));
      check($sformatf("w1 cout %0d", t), 32'(out_cout1), 32'(exp_c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
